// File: rtl/progmem_loader_pkg.sv
// progmem_loader_pkg: shared types for the boot-time program-memory loader.
//   state_t       - loader FSM states
//   SYNC_BYTE_DEF - default frame start marker
//   len_t         - 16-bit image length (word count)
package progmem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef logic [15:0] len_t;

endpackage

// File: rtl/progmem_loader_if.sv
// progmem_loader_if: host byte stream plus program-memory write port.
//   in_data/in_valid/in_ready - byte stream, transfer on in_valid && in_ready
//   mem_we/mem_addr/mem_wdata - one-cycle word write strobe into progmem
// Modports: slave = loader side, master = host/memory side.
interface progmem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/progmem_word_assembler.sv
// progmem_word_assembler: packs four bytes into a little-endian 32-bit word.
//   clk        - clock
//   clear      - synchronous clear of the byte counter and partial word
//   byte_en    - byte accepted this cycle
//   byte_in    - the byte
//   word_valid - combinational pulse on the 4th byte of a word
//   word       - assembled word, valid with word_valid (byte0 in [7:0])
module progmem_word_assembler (
  input  logic        clk,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  // Only the first three bytes need storage; the 4th is taken straight
  // from the input when the word is presented.
  logic [23:0] sreg;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt  <= 2'd0;
      sreg <= 24'd0;
    end else if (byte_en) begin
      cnt  <= cnt + 2'd1;
      sreg <= {byte_in, sreg[23:8]};
    end
  end

  assign word_valid = byte_en && !clear && (cnt == 2'd3);
  assign word       = {byte_in, sreg};

endmodule

// File: rtl/progmem_loader.sv
// progmem_loader: boot-time writer for the core's instruction memory.
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, N x 4 data bytes (little-endian words),
// and a trailing XOR checksum byte when PROGMEM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   bus         - progmem_loader_if.slave: byte stream in, progmem write out
//   reload      - pulse in DONE/ERR to restart loading
//   core_reset  - holds the core in reset until the image is loaded
//   done, error - sticky status
module progmem_loader
  import progmem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         MAX_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  progmem_loader_if.slave   bus,
  input  logic              reload,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  state_t      state;
  logic [7:0]  len_lo;
  len_t        n_words;
  len_t        word_idx;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        accept;
  len_t        len_rx;
  logic        word_valid;
  logic [31:0] word;

  assign accept = bus.in_valid && bus.in_ready;
  assign len_rx = {bus.in_data, len_lo};

  // Counter is held clear outside DATA so every image starts word-aligned.
  progmem_word_assembler u_asm (
    .clk        (clk),
    .clear      (reset || (state != S_DATA)),
    .byte_en    (accept && (state == S_DATA)),
    .byte_in    (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'd0;
      core_reset    <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      len_lo        <= 8'd0;
      n_words       <= '0;
      word_idx      <= '0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      csum          <= 8'd0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (bus.in_data == SYNC_BYTE)) begin
            state <= S_LEN_LO;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
            csum  <= 8'd0;
`endif
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= bus.in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            n_words <= len_rx;
            // Compared wide so MAX_WORDS == 65536 still works.
            if (32'(len_rx) > 32'(MAX_WORDS)) begin
              state        <= S_ERR;
              bus.in_ready <= 1'b0;
              error        <= 1'b1;
            end else if (len_rx == 16'd0) begin
`ifdef PROGMEM_LOADER_CHECKSUM_EN
              state        <= S_CSUM;
`else
              state        <= S_DONE;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
              core_reset   <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          if (accept) csum <= csum ^ bus.in_data;
`endif
          if (word_valid) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ADDR_W'(word_idx);
            bus.mem_wdata <= word;
            word_idx      <= word_idx + 16'd1;
            // Leaving DATA on the same edge as the final strobe keeps
            // core_reset asserted until that write lands.
            if (word_idx == n_words - 16'd1) begin
`ifdef PROGMEM_LOADER_CHECKSUM_EN
              state        <= S_CSUM;
`else
              state        <= S_DONE;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
              core_reset   <= 1'b0;
`endif
            end
          end
        end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERR: begin
          if (reload) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            core_reset   <= 1'b1;
            len_lo       <= 8'd0;
            n_words      <= '0;
            word_idx     <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_progmem_loader.sv
// tb_progmem_loader: randomized frames checked against a frame-level
// reference model (parses the byte list into expected writes and status).
module tb_progmem_loader;
  import progmem_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, reload;
  logic core_reset, done, error;

  progmem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  progmem_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .reload     (reload),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [ADDR_W-1:0] obs_addr[$];
  logic [31:0]       obs_data[$];
  logic              obs_done[$];
  int                b2b    = 0;
  int                cr_bad = 0;
  logic              prev_we = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we === 1'b1) begin
        obs_addr.push_back(bus.mem_addr);
        obs_data.push_back(bus.mem_wdata);
        obs_done.push_back(done);
        if (prev_we) b2b <= b2b + 1;
      end
      if (core_reset !== ~done) cr_bad <= cr_bad + 1;
    end
    prev_we <= (bus.mem_we === 1'b1) && !reset;
  end

  // ---------------- reference model ----------------
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_st;        // 0 still loading, 1 done, 2 error

  task automatic model(input logic [7:0] f[$]);
    int i, n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_st = 0;
    i = 0;
    while (i < f.size() && f[i] != 8'hA5) i++;
    if (i + 2 >= f.size()) return;
    n = int'(f[i+1]) + 256 * int'(f[i+2]);
    i += 3;
    if (n > MAX_WORDS) begin
      exp_st = 2;
      return;
    end
    x = 8'd0;
    for (int w = 0; w < n; w++) begin
      if (i + 4 > f.size()) return;
      exp_addr.push_back(w % (1 << ADDR_W));
      exp_data.push_back({f[i+3], f[i+2], f[i+1], f[i]});
      x = x ^ f[i] ^ f[i+1] ^ f[i+2] ^ f[i+3];
      i += 4;
    end
    if (CSUM) begin
      if (i >= f.size()) return;
      exp_st = (f[i] == x) ? 1 : 2;
    end else begin
      exp_st = 1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] fr[$];
  bit         rnd_reload = 1'b0;

  // XOR of data bytes following the header of the frame held in fr.
  function automatic logic [7:0] data_xor();
    int i;
    logic [7:0] x;
    x = 8'd0;
    i = 0;
    while (i < fr.size() && fr[i] != 8'hA5) i++;
    for (int k = i + 3; k < fr.size(); k++) x = x ^ fr[k];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    repeat ($urandom_range(0, 2)) begin
      bus.in_valid = 1'b0;
      reload = rnd_reload && ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    reload = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      chk("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    int nw;
    obs_addr.delete();
    obs_data.delete();
    obs_done.delete();
    model(fr);
    foreach (fr[k]) send_byte(fr[k]);
    repeat (3) @(negedge clk);
    nw = exp_addr.size();
    chk({tag, "_nwr"}, obs_addr.size(), nw);
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
      chk($sformatf("%s_donew%0d", tag, i), obs_done[i],
          (i == nw - 1) && (exp_st == 1) && !CSUM);
    end
    chk({tag, "_done"},   done,         exp_st == 1);
    chk({tag, "_error"},  error,        exp_st == 2);
    chk({tag, "_rdy"},    bus.in_ready, exp_st == 0);
    chk({tag, "_corerst"}, core_reset,  exp_st != 1);
    if (exp_st != 0) begin
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk({tag, "_rl_done"},    done,         1'b0);
      chk({tag, "_rl_error"},   error,        1'b0);
      chk({tag, "_rl_rdy"},     bus.in_ready, 1'b1);
      chk({tag, "_rl_corerst"}, core_reset,   1'b1);
    end
  endtask

  task automatic mk_random(input int idx);
    int ng, n, kind;
    kind = $urandom_range(0, 7);
    fr.delete();
    ng = $urandom_range(0, 3);
    repeat (ng) begin
      logic [7:0] g;
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h00;
      fr.push_back(g);
    end
    if (kind == 0)      n = 0;
    else if (kind == 1) n = MAX_WORDS + 1 + $urandom_range(0, 65535 - MAX_WORDS - 1);
    else                n = $urandom_range(1, 6);
    fr.push_back(8'hA5);
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    if (n <= MAX_WORDS) begin
      repeat (4 * n) fr.push_back(8'($urandom));
      if (CSUM) begin
        logic [7:0] x;
        x = data_xor();
        if ($urandom_range(0, 3) == 0) x = x ^ (8'd1 << $urandom_range(0, 7));
        fr.push_back(x);
      end
    end
    run_frame($sformatf("rnd%0d", idx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy",     bus.in_ready,  1'b1);
    chk("rst_we",      bus.mem_we,    1'b0);
    chk("rst_addr",    bus.mem_addr,  0);
    chk("rst_wdata",   bus.mem_wdata, 0);
    chk("rst_corerst", core_reset,    1'b1);
    chk("rst_done",    done,          1'b0);
    chk("rst_error",   error,         1'b0);
    reset = 1'b0;
    @(negedge clk);

    // two-word image
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    if (CSUM) fr.push_back(data_xor());
    run_frame("t1");
    if (obs_data.size() == 2) begin
      chk("t1_w0_const", obs_data[0], 32'h00500013);
      chk("t1_w1_const", obs_data[1], 32'h00100093);
    end

    // leading garbage
    fr = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    if (CSUM) fr.push_back(data_xor());
    run_frame("t2");
    if (obs_data.size() == 1) chk("t2_w0_const", obs_data[0], 32'hDEADBEEF);

    // length one past the limit
    fr = '{8'hA5, 8'h01, 8'h01};
    run_frame("t3");

    // empty image
    fr = '{8'hA5, 8'h00, 8'h00};
    if (CSUM) fr.push_back(8'h00);
    run_frame("t4");
    if (CSUM) begin
      fr = '{8'hA5, 8'h00, 8'h00, 8'h01};
      run_frame("t4b");
      fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
      run_frame("t6a");
      fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
      run_frame("t6b");
      if (obs_data.size() == 1) chk("t6b_w0_const", obs_data[0], 32'h08040201);
    end

    // reset in the middle of word 1
    obs_addr.delete();
    obs_data.delete();
    obs_done.delete();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
    foreach (fr[k]) send_byte(fr[k]);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_wdata",   bus.mem_wdata, 0);
    chk("t5_rst_corerst", core_reset,    1'b1);
    chk("t5_rst_rdy",     bus.in_ready,  1'b1);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_nwr", obs_addr.size(), 1);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    if (CSUM) fr.push_back(data_xor());
    run_frame("t5r");

    // largest accepted image
    fr = '{8'hA5, 8'h00, 8'h01};
    repeat (4 * MAX_WORDS) fr.push_back(8'($urandom));
    if (CSUM) fr.push_back(data_xor());
    run_frame("tmax");

    // randomized frames, with stray reload pulses mid-frame
    rnd_reload = 1'b1;
    for (int i = 0; i < 20; i++) mk_random(i);
    rnd_reload = 1'b0;

    chk("no_b2b_we",     b2b,    0);
    chk("corerst_vs_done", cr_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
